// File: rtl/rob_walk_ctrl_pkg.sv
// Shared ROB index type and flag-aware age/distance helpers used by ROB, rename and squash recovery.
// An index is {flag, idx}; because depth is a power of two, plain modular arithmetic on the
// concatenation is exactly the flag-aware arithmetic.
package rob_walk_ctrl_pkg;

  localparam int unsigned ROB_DEPTH = 64;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic             flag;
    logic [IDX_W-1:0] idx;
  } robIdx_t;

  typedef logic [IDX_W:0] robDist_t;

  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

  function automatic robIdx_t rob_add(input robIdx_t a, input robDist_t n);
    return robIdx_t'(robDist_t'(a) + n);
  endfunction

  function automatic robIdx_t rob_sub(input robIdx_t a, input robDist_t n);
    return robIdx_t'(robDist_t'(a) - n);
  endfunction

  // Entries from a (exclusive) up to b, modulo twice the ROB depth.
  function automatic robDist_t rob_dist(input robIdx_t a, input robIdx_t b);
    return robDist_t'(b) - robDist_t'(a);
  endfunction

endpackage

// File: rtl/rob_walk_lanes.sv
// Lane generator for the squash walk: lane k carries ptr - k and is valid while k < rem.
// Purely combinational; fed from registered state only.
module rob_walk_lanes
  import rob_walk_ctrl_pkg::*;
#(
  parameter int unsigned WALK_WIDTH = 4
) (
  input  robIdx_t                  ptr_i,
  input  robDist_t                 rem_i,
  output logic [WALK_WIDTH-1:0]    lane_vld_o,
  output robIdx_t [WALK_WIDTH-1:0] lane_idx_o
);

  always_comb begin
    lane_vld_o = '0;
    lane_idx_o = '0;
    for (int k = 0; k < WALK_WIDTH; k++) begin
      lane_vld_o[k] = robDist_t'(k) < rem_i;
      lane_idx_o[k] = rob_sub(ptr_i, robDist_t'(k));
    end
  end

endmodule

// File: rtl/rob_walk_ctrl.sv
// Squash-recovery sequencer: stall, drain DRAIN_CYCLES, walk squashed entries youngest-first
// up to WALK_WIDTH per accepted beat, then pulse done. A beat holds while i_walk_rdy is low.
module rob_walk_ctrl
  import rob_walk_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE     = ROB_DEPTH,
  parameter int unsigned WALK_WIDTH   = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_squash_vld,
  input  robIdx_t                  i_squash_robIdx,
  input  robIdx_t                  i_rob_tail,
  input  logic                     i_walk_rdy,
  output logic [WALK_WIDTH-1:0]    o_walk_vld,
  output robIdx_t [WALK_WIDTH-1:0] o_walk_robIdx,
  output logic                     o_stall,
  output logic                     o_walk_done
);

  localparam int unsigned      CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam robDist_t         MAX_WALK = robDist_t'(ROB_SIZE - 1);
  localparam robDist_t         LANES    = robDist_t'(WALK_WIDTH);
  localparam robDist_t         DIST_ONE = robDist_t'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WALK, S_DONE} state_e;

  state_e           state_q;
  robIdx_t          ptr_q;
  robIdx_t          end_q;
  robDist_t         rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stall_q;
  logic             done_q;

  robDist_t                 n_beat;
  robDist_t                 rem_adv;
  robDist_t                 nest_rem;
  robDist_t                 tail_dist;
  robDist_t                 rem_load;
  robIdx_t                  ptr_adv;
  logic                     accept;
  logic                     nest;
  logic [WALK_WIDTH-1:0]    lane_vld;
  robIdx_t [WALK_WIDTH-1:0] lane_idx;

  rob_walk_lanes #(
    .WALK_WIDTH(WALK_WIDTH)
  ) u_lanes (
    .ptr_i      (ptr_q),
    .rem_i      (rem_q),
    .lane_vld_o (lane_vld),
    .lane_idx_o (lane_idx)
  );

  always_comb begin
    n_beat    = (rem_q > LANES) ? LANES : rem_q;
    accept    = (state_q == S_WALK) && i_walk_rdy;
    ptr_adv   = accept ? rob_sub(ptr_q, n_beat) : ptr_q;
    rem_adv   = accept ? (rem_q - n_beat) : rem_q;
    // A nested squash re-targets from wherever the walk stands after this cycle's beat.
    nest      = i_squash_vld && (state_q != S_IDLE) && rob_older(i_squash_robIdx, end_q);
    nest_rem  = rob_dist(i_squash_robIdx, ptr_adv);
    tail_dist = rob_dist(i_squash_robIdx, i_rob_tail);
    if (tail_dist == '0) begin
      rem_load = '0;
    end else if ((tail_dist - DIST_ONE) > MAX_WALK) begin
      rem_load = MAX_WALK;
    end else begin
      rem_load = tail_dist - DIST_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_squash_vld) begin
            ptr_q   <= rob_sub(i_rob_tail, DIST_ONE);
            end_q   <= i_squash_robIdx;
            rem_q   <= rem_load;
            cnt_q   <= CNT_INIT;
            stall_q <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (nest) begin
            end_q <= i_squash_robIdx;
            rem_q <= nest_rem;
            cnt_q <= CNT_INIT;
          end else if (cnt_q == CNT_ONE) begin
            state_q <= (rem_q == '0) ? S_DONE : S_WALK;
            done_q  <= (rem_q == '0);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_WALK: begin
          ptr_q <= ptr_adv;
          if (nest) begin
            end_q <= i_squash_robIdx;
            rem_q <= nest_rem;
          end else begin
            rem_q <= rem_adv;
            if (accept && (rem_adv == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (nest) begin
            end_q <= i_squash_robIdx;
            rem_q <= nest_rem;
            if (nest_rem == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_WALK;
            end
          end else begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_walk_vld    = (state_q == S_WALK) ? lane_vld : '0;
  assign o_walk_robIdx = (state_q == S_WALK) ? lane_idx : '0;
  assign o_stall       = stall_q;
  assign o_walk_done   = done_q;

endmodule

// File: tb/tb_rob_walk_ctrl.sv
// Directed bench for rob_walk_ctrl: per-cycle expectation tables for each recovery scenario.
module tb_rob_walk_ctrl;
  import rob_walk_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_squash_vld = 1'b0;
  robIdx_t           i_squash_robIdx = '0;
  robIdx_t           i_rob_tail = '0;
  logic              i_walk_rdy = 1'b0;
  logic [3:0]        o_walk_vld;
  robIdx_t [3:0]     o_walk_robIdx;
  logic              o_stall;
  logic              o_walk_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  rob_walk_ctrl #(
    .ROB_SIZE     (64),
    .WALK_WIDTH   (4),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_squash_vld    (i_squash_vld),
    .i_squash_robIdx (i_squash_robIdx),
    .i_rob_tail      (i_rob_tail),
    .i_walk_rdy      (i_walk_rdy),
    .o_walk_vld      (o_walk_vld),
    .o_walk_robIdx   (o_walk_robIdx),
    .o_stall         (o_stall),
    .o_walk_done     (o_walk_done)
  );

  always #5 clk = ~clk;

  function automatic robIdx_t mk(input int f, input int i);
    robIdx_t r;
    r.flag = f[0];
    r.idx  = IDX_W'(i);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    i_squash_vld = 1'b1;
    i_squash_robIdx = mk(0, 3);
    i_rob_tail = mk(0, 9);
    i_walk_rdy = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (o_stall !== 1'b0 || o_walk_done !== 1'b0 || o_walk_vld !== 4'h0 || o_walk_robIdx !== '0) begin
      err_cnt++;
      $display("FAIL reset_hold stall/done/vld/idx got %b/%b/%b/%h want 0/0/0000/0",
               o_stall, o_walk_done, o_walk_vld, o_walk_robIdx);
    end
    rst = 1'b1;
    i_squash_vld = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (o_stall !== 1'b0 || o_walk_done !== 1'b0 || o_walk_vld !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_release stall/done/vld got %b/%b/%b want 0/0/0000",
               o_stall, o_walk_done, o_walk_vld);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ev [8] = '{4'h0, 4'h0, 4'h0, 4'hf, 4'hf, 4'h1, 4'h0, 4'h0};
    logic [6:0] eb [8] = '{7'd0, 7'd0, 7'd0, 7'd19, 7'd15, 7'd11, 7'd0, 7'd0};
    logic [7:0] es = 8'b0111_1110;
    logic [7:0] ed = 8'b0100_0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== ed[c] || o_walk_vld !== ev[c]) begin
        err_cnt++;
        $display("FAIL basic c%0d stall/done/vld got %b/%b/%b want %b/%b/%b",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ed[c], ev[c]);
      end
      for (int k = 0; k < 4; k++) begin
        if (ev[c][k]) begin
          vec_cnt++;
          if (o_walk_robIdx[k] !== robIdx_t'(eb[c] - 7'(k))) begin
            err_cnt++;
            $display("FAIL basic_lane c%0d lane%0d got %h want %h", c, k, o_walk_robIdx[k], eb[c] - 7'(k));
          end
        end
      end
      i_squash_vld = (c == 0);
      i_squash_robIdx = mk(0, 10);
      i_rob_tail = mk(0, 20);
      i_walk_rdy = 1'b1;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ev [6] = '{4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0};
    robIdx_t    el [3];
    logic [5:0] es = 6'b01_1110;
    logic [5:0] ed = 6'b01_0000;
    el[0] = mk(1, 1);
    el[1] = mk(1, 0);
    el[2] = mk(0, 63);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== ed[c] || o_walk_vld !== ev[c]) begin
        err_cnt++;
        $display("FAIL wrap c%0d stall/done/vld got %b/%b/%b want %b/%b/%b",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ed[c], ev[c]);
      end
      if (c == 3) begin
        for (int k = 0; k < 3; k++) begin
          vec_cnt++;
          if (o_walk_robIdx[k] !== el[k]) begin
            err_cnt++;
            $display("FAIL wrap_lane lane%0d got %h want %h", k, o_walk_robIdx[k], el[k]);
          end
        end
      end
      i_squash_vld = (c == 0);
      i_squash_robIdx = mk(0, 62);
      i_rob_tail = mk(1, 2);
      i_walk_rdy = 1'b1;
    end
  endtask

  task automatic test_zero();
    logic [4:0] es = 5'b0_1110;
    logic [4:0] ed = 5'b0_1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== ed[c] || o_walk_vld !== 4'h0) begin
        err_cnt++;
        $display("FAIL zero c%0d stall/done/vld got %b/%b/%b want %b/%b/0000",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ed[c]);
      end
      i_squash_vld = (c == 0);
      i_squash_robIdx = mk(0, 5);
      i_rob_tail = mk(0, 6);
      i_walk_rdy = 1'b1;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  ev [11] = '{4'h0, 4'h0, 4'h0, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'h1, 4'h0, 4'h0};
    logic [6:0]  eb [11] = '{7'd0, 7'd0, 7'd0, 7'd19, 7'd15, 7'd15, 7'd15, 7'd15, 7'd11, 7'd0, 7'd0};
    logic [10:0] es = 11'b011_1111_1110;
    logic [10:0] ed = 11'b010_0000_0000;
    logic [10:0] rd = 11'b111_1000_1111;
    int beats = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== ed[c] || o_walk_vld !== ev[c]) begin
        err_cnt++;
        $display("FAIL bp c%0d stall/done/vld got %b/%b/%b want %b/%b/%b",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ed[c], ev[c]);
      end
      for (int k = 0; k < 4; k++) begin
        if (ev[c][k]) begin
          vec_cnt++;
          if (o_walk_robIdx[k] !== robIdx_t'(eb[c] - 7'(k))) begin
            err_cnt++;
            $display("FAIL bp_lane c%0d lane%0d got %h want %h", c, k, o_walk_robIdx[k], eb[c] - 7'(k));
          end
        end
      end
      i_squash_vld = (c == 0);
      i_squash_robIdx = mk(0, 10);
      i_rob_tail = mk(0, 20);
      i_walk_rdy = rd[c];
      if (o_walk_vld != 4'h0 && i_walk_rdy) beats++;
    end
    vec_cnt++;
    if (beats !== 3) begin
      err_cnt++;
      $display("FAIL bp_beats got %0d want 3", beats);
    end
  endtask

  task automatic test_nested();
    logic [3:0] ev [9] = '{4'h0, 4'h0, 4'h0, 4'hf, 4'hf, 4'hf, 4'h7, 4'h0, 4'h0};
    logic [6:0] eb [9] = '{7'd0, 7'd0, 7'd0, 7'd19, 7'd15, 7'd11, 7'd7, 7'd0, 7'd0};
    logic [8:0] es = 9'b0_1111_1110;
    logic [8:0] ed = 9'b0_1000_0000;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== ed[c] || o_walk_vld !== ev[c]) begin
        err_cnt++;
        $display("FAIL nested c%0d stall/done/vld got %b/%b/%b want %b/%b/%b",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ed[c], ev[c]);
      end
      for (int k = 0; k < 4; k++) begin
        if (ev[c][k]) begin
          vec_cnt++;
          if (o_walk_robIdx[k] !== robIdx_t'(eb[c] - 7'(k))) begin
            err_cnt++;
            $display("FAIL nested_lane c%0d lane%0d got %h want %h", c, k, o_walk_robIdx[k], eb[c] - 7'(k));
          end
        end
      end
      i_walk_rdy = 1'b1;
      i_squash_vld = (c == 0) || (c == 3) || (c == 5);
      i_squash_robIdx = (c == 0) ? mk(0, 10) : (c == 3) ? mk(0, 4) : mk(0, 15);
      i_rob_tail = (c == 0) ? mk(0, 20) : mk(0, 40);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ev [8] = '{4'h0, 4'h0, 4'h0, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0};
    logic [7:0] es = 8'b0001_1110;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_stall !== es[c] || o_walk_done !== 1'b0 || o_walk_vld !== ev[c]) begin
        err_cnt++;
        $display("FAIL rstmid c%0d stall/done/vld got %b/%b/%b want %b/0/%b",
                 c, o_stall, o_walk_done, o_walk_vld, es[c], ev[c]);
      end
      if (c == 5) begin
        vec_cnt++;
        if (o_walk_robIdx !== '0) begin
          err_cnt++;
          $display("FAIL rstmid_idx got %h want 0", o_walk_robIdx);
        end
      end
      i_squash_vld = (c == 0);
      i_squash_robIdx = mk(0, 10);
      i_rob_tail = mk(0, 20);
      i_walk_rdy = 1'b1;
      rst = (c == 4) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_nested();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
